mpu_ldst_engine: RTL and testbench
==================================

# mpu_ldst_engine

Synthesizable load/store engine between the external element stream and the MPU matrix register file. It loads a row-major matrix one element per beat into one of `NUM_REGS` matrix registers, and streams a stored matrix back out with backpressure. It also records per-register dimensions and rejects malformed requests. It sits between the testbench/memory side (driven by the MPU BFM) and the MPU arithmetic datapath.

## Interface
Parameters:
- `FP`, 32: element width in bits (32 or 64).
- `M`, 4: maximum rows per matrix.
- `N`, 4: maximum columns per matrix.
- `NUM_REGS`, 4: number of matrix registers.
- Derived: `MBITS = $clog2(M)`, `NBITS = $clog2(N)`, `RBITS = $clog2(NUM_REGS)`.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  chip enable; deasserting it aborts any operation.
- `load_en`  in  1  load request (sampled in IDLE).
- `store_en`  in  1  store request (sampled in IDLE).
- `matrix_m_size`  in  MBITS+1  rows of the matrix to load.
- `matrix_n_size`  in  NBITS+1  columns of the matrix to load.
- `load_addr`  in  RBITS  destination register for a load.
- `store_addr`  in  RBITS  source register for a store.
- `element`  in  FP  input element.
- `element_valid`  in  1  `element` is valid this cycle.
- `ack`  out  1  operation in progress.
- `error`  out  1  one-cycle pulse: request rejected.
- `element_out`  out  FP  output element.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  consumer accepts the beat.
- `m_out`  out  MBITS+1  row index of the current output beat.
- `n_out`  out  NBITS+1  column index of the current output beat.
- `store_complete`  out  1  one-cycle pulse after the last store beat.

## Operation
- States: IDLE, LOAD, STORE.
- Reset (synchronous, wins over everything else):
  - state goes to IDLE.
  - All outputs are 0.
  - All register valid bits are cleared; array contents are don't-care.
- Request checks in IDLE (when `en`=1):
  - `load_en` and `store_en` both high → `error`.
  - Load with `m` outside 1..M, `n` outside 1..N, or `load_addr` ≥ NUM_REGS → `error`.
  - Store with `store_addr` ≥ NUM_REGS, or to a register whose valid bit is 0 → `error`.
  - On any `error`, state stays IDLE.
- LOAD (valid load request):
  - Latch `m`, `n`, and the address; zero the row/column counters; clear the target register's valid bit; go to LOAD.
  - Each cycle with `element_valid`=1, write `element` at (row, col) and advance col; on col wrap, col=0 and row+1.
  - After element m·n−1 is written: set the valid bit, store `m`/`n` with the register, go to IDLE.
- STORE (valid store request):
  - Use the register's stored `m`/`n`; stream elements row-major.
  - A beat transfers on an edge with `out_valid` & `out_ready`.
  - While not accepted, `element_out`, `m_out`, `n_out` hold stable.
- Abort: `en`=0 in LOAD or STORE returns to IDLE on the next edge.
  - An aborted load leaves the target register invalid.
  - An aborted store produces no `store_complete`.
- In LOAD and STORE, `load_en` and `store_en` are ignored.

## Timing
- Request accepted at edge k → `ack`=1 from cycle k+1.
- Rejected request at edge k → `error`=1 during cycle k+1 only; `ack` stays 0.
- Load:
  - Element i is captured at the i-th edge with `ack`=1 and `element_valid`=1.
  - `ack` falls in the cycle after the final capture.
  - A load of m·n elements with continuous valid holds `ack` high for exactly m·n cycles.
- Store:
  - First beat valid in cycle k+1; outputs are registered.
  - With `out_ready` held high, one beat per cycle.
  - After the final beat is accepted at edge j: `out_valid`=0, `ack`=0, and `store_complete`=1 during cycle j+1.
- Back-to-back: a new request is accepted at the first edge in IDLE, i.e. earliest one cycle after `ack` falls.
- Loading a register and storing it immediately afterwards returns the new data; there is no stale read.

## Structure
- Shared package `mpu_pkg`:
  - `mpu_state_t` (IDLE/LOAD/STORE).
  - `mpu_operation_t`, extended with LOAD/STORE/NOP.
  - Defaults for FP/M/N/NUM_REGS in `global_defs`.
- Sub-module `mpu_matrix_regfile`:
  - NUM_REGS × M·N × FP storage, one write port and one read port.
  - Per-register valid bit and stored m/n.
  - Reset clears valid bits only.
- The FSM, counters and handshake logic live in `mpu_ldst_engine`.

## Test plan
- Reset: hold `rst` for 10 cycles → `ack`/`error`/`out_valid`/`store_complete`=0, and a store to reg 0 gives an `error` pulse.
- Load then store: load 2×3 {1.0..6.0} (0x3F800000…) into reg 2, then store reg 2 with `out_ready`=1 → six beats in order, (m_out,n_out)=(0,0)…(1,2), `store_complete` exactly one cycle after the last beat.
- Backpressure and gaps: toggle `out_ready` 1,0,0,1 during a 4×4 store → beats held stable, no loss or duplication. Insert `element_valid` gaps during a load → `ack` is stretched by the number of gap cycles.
- Rejected requests, each → one `error` pulse and `ack` stays 0:
  - load `m`=0;
  - load `n`=N+1;
  - `load_en` & `store_en` together;
  - store to a never-loaded reg 3.
- Abort: drop `en` after 3 elements of a 2×2 load to reg 1 → state IDLE next cycle; a later store to reg 1 gives `error`.
- Reset mid-store: assert `rst` during beat 5 of a 4×4 store → all outputs 0 on the next cycle, and all registers are invalid afterwards.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared defaults plus the state and operation types used by the MPU load/store path.
package global_defs;
  localparam int FP_DEF       = 32;
  localparam int M_DEF        = 4;
  localparam int N_DEF        = 4;
  localparam int NUM_REGS_DEF = 4;
endpackage

package mpu_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STORE} mpu_state_t;
  typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_STORE} mpu_operation_t;

  // Row-major position of (row, col) inside one matrix register.
  function automatic int flat_index(input int row, input int col, input int ncols);
    return row * ncols + col;
  endfunction
endpackage

// File: rtl/mpu_ldst_engine_if.sv
// Element-stream and request bundle between the MPU BFM (master) and the load/store engine (slave).
interface mpu_ldst_engine_if #(
  parameter int FP       = global_defs::FP_DEF,
  parameter int M        = global_defs::M_DEF,
  parameter int N        = global_defs::N_DEF,
  parameter int NUM_REGS = global_defs::NUM_REGS_DEF
) ();
  localparam int MBITS = $clog2(M);
  localparam int NBITS = $clog2(N);
  localparam int RBITS = $clog2(NUM_REGS);

  logic             en;
  logic             load_en;
  logic             store_en;
  logic [MBITS:0]   matrix_m_size;
  logic [NBITS:0]   matrix_n_size;
  logic [RBITS-1:0] load_addr;
  logic [RBITS-1:0] store_addr;
  logic [FP-1:0]    element;
  logic             element_valid;
  logic             ack;
  logic             error;
  logic [FP-1:0]    element_out;
  logic             out_valid;
  logic             out_ready;
  logic [MBITS:0]   m_out;
  logic [NBITS:0]   n_out;
  logic             store_complete;

  modport master (
    output en, load_en, store_en, matrix_m_size, matrix_n_size, load_addr, store_addr,
           element, element_valid, out_ready,
    input  ack, error, element_out, out_valid, m_out, n_out, store_complete
  );

  modport slave (
    input  en, load_en, store_en, matrix_m_size, matrix_n_size, load_addr, store_addr,
           element, element_valid, out_ready,
    output ack, error, element_out, out_valid, m_out, n_out, store_complete
  );
endinterface

// File: rtl/mpu_ldst_engine_regfile.sv
// Matrix register file: NUM_REGS matrices of M*N elements, one write and one async read port,
// plus a valid bit and the loaded dimensions for every register.
module mpu_matrix_regfile
  import mpu_pkg::*;
#(
  parameter int FP       = 32,
  parameter int M        = 4,
  parameter int N        = 4,
  parameter int NUM_REGS = 4,
  localparam int MBITS   = $clog2(M),
  localparam int NBITS   = $clog2(N),
  localparam int RBITS   = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [RBITS-1:0] waddr_i,
  input  logic [MBITS:0]   wrow_i,
  input  logic [NBITS:0]   wcol_i,
  input  logic [FP-1:0]    wdata_i,
  input  logic             set_valid_i,
  input  logic             clr_valid_i,
  input  logic [RBITS-1:0] vaddr_i,
  input  logic [MBITS:0]   vm_i,
  input  logic [NBITS:0]   vn_i,
  input  logic [RBITS-1:0] raddr_i,
  input  logic [MBITS:0]   rrow_i,
  input  logic [NBITS:0]   rcol_i,
  output logic [FP-1:0]    rdata_o,
  output logic             rvalid_o,
  output logic [MBITS:0]   rm_o,
  output logic [NBITS:0]   rn_o
);
  localparam int DEPTH = NUM_REGS * M * N;
  localparam int ABITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FP-1:0]       mem_q [DEPTH];
  logic [MBITS:0]      m_q   [NUM_REGS];
  logic [NBITS:0]      n_q   [NUM_REGS];
  logic [NUM_REGS-1:0] valid_q;
  logic [ABITS-1:0]    widx;
  logic [ABITS-1:0]    ridx;

  assign widx = ABITS'(int'(waddr_i) * M * N + flat_index(int'(wrow_i), int'(wcol_i), N));
  assign ridx = ABITS'(int'(raddr_i) * M * N + flat_index(int'(rrow_i), int'(rcol_i), N));

  // Contents and dimensions carry no reset; only the valid bits decide what may be stored.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[widx] <= wdata_i;
    if (set_valid_i) begin
      m_q[vaddr_i] <= vm_i;
      n_q[vaddr_i] <= vn_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else if (set_valid_i) valid_q[vaddr_i] <= 1'b1;
    else if (clr_valid_i) valid_q[vaddr_i] <= 1'b0;
  end

  assign rdata_o  = mem_q[ridx];
  assign rvalid_o = valid_q[raddr_i];
  assign rm_o     = m_q[raddr_i];
  assign rn_o     = n_q[raddr_i];
endmodule

// File: rtl/mpu_ldst_engine.sv
// Load/store engine: streams row-major matrices into the register file and back out with
// backpressure, validating requests and tracking per-register dimensions.
module mpu_ldst_engine
  import mpu_pkg::*;
#(
  parameter int FP       = global_defs::FP_DEF,
  parameter int M        = global_defs::M_DEF,
  parameter int N        = global_defs::N_DEF,
  parameter int NUM_REGS = global_defs::NUM_REGS_DEF
) (
  input logic               clk,
  input logic               rst,
  mpu_ldst_engine_if.slave  bus
);
  localparam int MBITS = $clog2(M);
  localparam int NBITS = $clog2(N);
  localparam int RBITS = $clog2(NUM_REGS);
  localparam logic [MBITS:0] M_ONE = 1;
  localparam logic [NBITS:0] N_ONE = 1;

  mpu_state_t       state_q, state_d;
  mpu_operation_t   op;
  logic [MBITS:0]   row_q, row_d, m_q, m_d, nxt_row;
  logic [NBITS:0]   col_q, col_d, n_q, n_d, nxt_col;
  logic [RBITS-1:0] addr_q, addr_d;
  logic [FP-1:0]    dout_q, dout_d;
  logic             oval_q, oval_d, err_q, err_d, done_q, done_d;
  logic             last_col, last_row, load_bad, store_bad;

  logic             we, set_v, clr_v, rvalid;
  logic [RBITS-1:0] vaddr, raddr;
  logic [MBITS:0]   rrow, rm;
  logic [NBITS:0]   rcol, rn;
  logic [FP-1:0]    rdata;

  mpu_matrix_regfile #(.FP(FP), .M(M), .N(N), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we),
    .waddr_i     (addr_q),
    .wrow_i      (row_q),
    .wcol_i      (col_q),
    .wdata_i     (bus.element),
    .set_valid_i (set_v),
    .clr_valid_i (clr_v),
    .vaddr_i     (vaddr),
    .vm_i        (m_q),
    .vn_i        (n_q),
    .raddr_i     (raddr),
    .rrow_i      (rrow),
    .rcol_i      (rcol),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .rm_o        (rm),
    .rn_o        (rn)
  );

  assign last_col = (col_q == n_q - N_ONE);
  assign last_row = (row_q == m_q - M_ONE);
  assign nxt_col  = last_col ? '0 : col_q + N_ONE;
  assign nxt_row  = last_col ? row_q + M_ONE : row_q;

  assign load_bad  = (bus.matrix_m_size == '0) || (int'(bus.matrix_m_size) > M) ||
                     (bus.matrix_n_size == '0) || (int'(bus.matrix_n_size) > N) ||
                     (int'(bus.load_addr) >= NUM_REGS);
  assign store_bad = (int'(bus.store_addr) >= NUM_REGS) || !rvalid;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    m_d     = m_q;
    n_d     = n_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    oval_d  = oval_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    we      = 1'b0;
    set_v   = 1'b0;
    clr_v   = 1'b0;
    vaddr   = addr_q;
    raddr   = addr_q;
    rrow    = nxt_row;
    rcol    = nxt_col;
    op      = OP_NOP;
    if (bus.load_en && !bus.store_en) op = OP_LOAD;
    else if (bus.store_en && !bus.load_en) op = OP_STORE;

    unique case (state_q)
      ST_IDLE: begin
        // In IDLE the read port previews element (0,0) and the dimensions of the store source.
        raddr = bus.store_addr;
        rrow  = '0;
        rcol  = '0;
        if (bus.en) begin
          if (bus.load_en && bus.store_en) begin
            err_d = 1'b1;
          end else if (op == OP_LOAD) begin
            if (load_bad) begin
              err_d = 1'b1;
            end else begin
              m_d     = bus.matrix_m_size;
              n_d     = bus.matrix_n_size;
              addr_d  = bus.load_addr;
              row_d   = '0;
              col_d   = '0;
              clr_v   = 1'b1;
              vaddr   = bus.load_addr;
              state_d = ST_LOAD;
            end
          end else if (op == OP_STORE) begin
            if (store_bad) begin
              err_d = 1'b1;
            end else begin
              m_d     = rm;
              n_d     = rn;
              addr_d  = bus.store_addr;
              row_d   = '0;
              col_d   = '0;
              dout_d  = rdata;
              oval_d  = 1'b1;
              state_d = ST_STORE;
            end
          end
        end
      end
      ST_LOAD: begin
        if (!bus.en) begin
          state_d = ST_IDLE;
        end else if (bus.element_valid) begin
          we    = 1'b1;
          row_d = nxt_row;
          col_d = nxt_col;
          if (last_col && last_row) begin
            set_v   = 1'b1;
            row_d   = '0;
            col_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_STORE: begin
        if (!bus.en) begin
          oval_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (oval_q && bus.out_ready) begin
          if (last_col && last_row) begin
            oval_d  = 1'b0;
            done_d  = 1'b1;
            row_d   = '0;
            col_d   = '0;
            state_d = ST_IDLE;
          end else begin
            row_d  = nxt_row;
            col_d  = nxt_col;
            dout_d = rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      m_q     <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      oval_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      m_q     <= m_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      oval_q  <= oval_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.ack            = (state_q != ST_IDLE);
  assign bus.error          = err_q;
  assign bus.element_out    = dout_q;
  assign bus.out_valid      = oval_q;
  assign bus.m_out          = row_q;
  assign bus.n_out          = col_q;
  assign bus.store_complete = done_q;
endmodule

// File: tb/tb_mpu_ldst_engine.sv
// Self-checking bench for mpu_ldst_engine: request table, directed load/store/abort/reset
// sequences, and randomized traffic against a matrix-level reference model.
module tb_mpu_ldst_engine;
  localparam int FP       = 32;
  localparam int M        = 4;
  localparam int N        = 4;
  localparam int NUM_REGS = 4;
  localparam int MW       = $clog2(M) + 1;
  localparam int NW       = $clog2(N) + 1;
  localparam int RW       = $clog2(NUM_REGS);

  typedef struct {
    bit en;
    bit ld;
    bit st;
    int m;
    int n;
    int la;
    int sa;
    bit expErr;
    bit expAck;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errorCount = 0;
  int   checkCount = 0;

  // Reference model: whole matrices per register, indexed row-major.
  logic [FP-1:0] refMem   [NUM_REGS][M*N];
  bit            refValid [NUM_REGS];
  int            refM     [NUM_REGS];
  int            refN     [NUM_REGS];
  logic [FP-1:0] stageData [M*N];
  vec_t          vecs [11];

  mpu_ldst_engine_if #(.FP(FP), .M(M), .N(N), .NUM_REGS(NUM_REGS)) bus ();

  mpu_ldst_engine #(.FP(FP), .M(M), .N(N), .NUM_REGS(NUM_REGS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input bit en, input bit ld, input bit st, input int m, input int n,
                                 input int la, input int sa, input bit expErr, input bit expAck);
    vec_t v;
    v.en = en; v.ld = ld; v.st = st; v.m = m; v.n = n;
    v.la = la; v.sa = sa; v.expErr = expErr; v.expAck = expAck;
    return v;
  endfunction

  // One-cycle request; accepted operations are aborted with en=0 so the next vector starts in IDLE.
  task automatic applyStimulus(input vec_t v, input string tag);
    bus.en            = v.en;
    bus.load_en       = v.ld;
    bus.store_en      = v.st;
    bus.matrix_m_size = MW'(v.m);
    bus.matrix_n_size = NW'(v.n);
    bus.load_addr     = RW'(v.la);
    bus.store_addr    = RW'(v.sa);
    tick();
    bus.load_en  = 1'b0;
    bus.store_en = 1'b0;
    bus.en       = 1'b1;
    checkOutput({tag, "_error"}, 64'(bus.error), 64'(v.expErr));
    checkOutput({tag, "_ack"}, 64'(bus.ack), 64'(v.expAck));
    if (v.expAck) begin
      if (v.ld) refValid[v.la] = 1'b0;
      bus.en = 1'b0;
      tick();
      bus.en = 1'b1;
      checkOutput({tag, "_abort_ack"}, 64'(bus.ack), 64'd0);
      checkOutput({tag, "_abort_out_valid"}, 64'(bus.out_valid), 64'd0);
      checkOutput({tag, "_abort_complete"}, 64'(bus.store_complete), 64'd0);
    end else begin
      tick();
      checkOutput({tag, "_error_pulse_end"}, 64'(bus.error), 64'd0);
      checkOutput({tag, "_ack_idle"}, 64'(bus.ack), 64'd0);
    end
  endtask

  // gapMode: 0 continuous, 1 every third cycle idle, 2 random idles.
  task automatic doLoad(input int ra, input int m, input int n, input int gapMode);
    int  idx, gaps, ackCycles, cyc;
    bit  gap;
    bus.load_en       = 1'b1;
    bus.load_addr     = RW'(ra);
    bus.matrix_m_size = MW'(m);
    bus.matrix_n_size = NW'(n);
    tick();
    bus.load_en = 1'b0;
    checkOutput("load_ack_rise", 64'(bus.ack), 64'd1);
    idx = 0; gaps = 0; ackCycles = 0; cyc = 0;
    while (idx < m * n && cyc < 400) begin
      gap = (gapMode == 1 && cyc % 3 == 2) || (gapMode == 2 && $urandom_range(3) == 0);
      if (gap) begin
        bus.element_valid = 1'b0;
        gaps++;
      end else begin
        bus.element_valid = 1'b1;
        bus.element       = stageData[idx];
      end
      if (bus.ack) ackCycles++;
      tick();
      if (!gap) idx++;
      cyc++;
    end
    bus.element_valid = 1'b0;
    checkOutput("load_finished_in_budget", 64'(idx), 64'(m * n));
    checkOutput("load_ack_fall", 64'(bus.ack), 64'd0);
    checkOutput("load_ack_length", 64'(ackCycles), 64'(m * n + gaps));
    refValid[ra] = 1'b1;
    refM[ra]     = m;
    refN[ra]     = n;
    for (int i = 0; i < m * n; i++) refMem[ra][i] = stageData[i];
  endtask

  // readyMode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic doStore(input int ra, input int readyMode);
    int beat, total, cyc;
    bit rdy;
    bus.store_en   = 1'b1;
    bus.store_addr = RW'(ra);
    tick();
    bus.store_en = 1'b0;
    checkOutput("store_ack_rise", 64'(bus.ack), 64'd1);
    total = refM[ra] * refN[ra];
    beat = 0; cyc = 0;
    while (beat < total && cyc < 500) begin
      case (readyMode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(1));
      endcase
      bus.out_ready = rdy;
      checkOutput("store_out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("store_element", 64'(bus.element_out), 64'(refMem[ra][beat]));
      checkOutput("store_m_out", 64'(bus.m_out), 64'(beat / refN[ra]));
      checkOutput("store_n_out", 64'(bus.n_out), 64'(beat % refN[ra]));
      checkOutput("store_complete_early", 64'(bus.store_complete), 64'd0);
      tick();
      if (rdy) beat++;
      cyc++;
    end
    bus.out_ready = 1'b0;
    checkOutput("store_beats_in_budget", 64'(beat), 64'(total));
    checkOutput("store_end_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("store_end_ack", 64'(bus.ack), 64'd0);
    checkOutput("store_complete_pulse", 64'(bus.store_complete), 64'd1);
    tick();
    checkOutput("store_complete_one_cycle", 64'(bus.store_complete), 64'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ack"}, 64'(bus.ack), 64'd0);
    checkOutput({tag, "_error"}, 64'(bus.error), 64'd0);
    checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, "_store_complete"}, 64'(bus.store_complete), 64'd0);
    checkOutput({tag, "_element_out"}, 64'(bus.element_out), 64'd0);
    checkOutput({tag, "_m_out"}, 64'(bus.m_out), 64'd0);
    checkOutput({tag, "_n_out"}, 64'(bus.n_out), 64'd0);
  endtask

  task automatic runRandom(input int iterations);
    int kind, m, n, ra;
    for (int it = 0; it < iterations; it++) begin
      kind = $urandom_range(0, 9);
      ra   = $urandom_range(0, NUM_REGS - 1);
      if (kind < 4) begin
        m = $urandom_range(0, 5);
        n = $urandom_range(0, 5);
        if (m >= 1 && m <= M && n >= 1 && n <= N) begin
          for (int i = 0; i < M * N; i++) stageData[i] = $urandom;
          doLoad(ra, m, n, 2);
        end else begin
          applyStimulus(mkVec(1, 1, 0, m, n, ra, 0, 1, 0), "rand_bad_load");
        end
      end else if (kind < 8) begin
        if (refValid[ra]) doStore(ra, 2);
        else applyStimulus(mkVec(1, 0, 1, 0, 0, 0, ra, 1, 0), "rand_store_invalid");
      end else begin
        applyStimulus(mkVec(1, 1, 1, 2, 2, ra, ra, 1, 0), "rand_both_requests");
      end
    end
  endtask

  initial begin
    bus.en = 1'b1; bus.load_en = 1'b0; bus.store_en = 1'b0;
    bus.matrix_m_size = '0; bus.matrix_n_size = '0;
    bus.load_addr = '0; bus.store_addr = '0;
    bus.element = '0; bus.element_valid = 1'b0; bus.out_ready = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      refValid[r] = 1'b0; refM[r] = 0; refN[r] = 0;
    end

    vecs[0]  = mkVec(1, 1, 0, 0, 2, 0, 0, 1, 0);
    vecs[1]  = mkVec(1, 1, 0, 2, N + 1, 0, 0, 1, 0);
    vecs[2]  = mkVec(1, 1, 1, 2, 2, 0, 2, 1, 0);
    vecs[3]  = mkVec(1, 0, 1, 0, 0, 0, 3, 1, 0);
    vecs[4]  = mkVec(1, 1, 0, M + 1, 1, 1, 0, 1, 0);
    vecs[5]  = mkVec(1, 1, 0, 3, 0, 1, 0, 1, 0);
    vecs[6]  = mkVec(1, 0, 1, 0, 0, 0, 1, 1, 0);
    vecs[7]  = mkVec(0, 1, 0, 2, 2, 0, 0, 0, 0);
    vecs[8]  = mkVec(1, 1, 0, 4, 4, 3, 0, 0, 1);
    vecs[9]  = mkVec(1, 0, 1, 0, 0, 0, 2, 0, 1);
    vecs[10] = mkVec(1, 0, 1, 0, 0, 0, 2, 0, 1);

    rst = 1'b1;
    repeat (10) tick();
    checkAllZero("reset");
    rst = 1'b0;
    applyStimulus(mkVec(1, 0, 1, 0, 0, 0, 0, 1, 0), "reset_store_reg0");

    stageData[0] = 32'h3F800000; stageData[1] = 32'h40000000; stageData[2] = 32'h40400000;
    stageData[3] = 32'h40800000; stageData[4] = 32'h40A00000; stageData[5] = 32'h40C00000;
    doLoad(2, 2, 3, 0);
    doStore(2, 0);

    for (int i = 0; i < M * N; i++) stageData[i] = $urandom;
    doLoad(0, 4, 4, 1);
    doStore(0, 1);

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Abort a 2x2 load into reg 1 after three captured elements.
    bus.load_en = 1'b1; bus.load_addr = 2'd1;
    bus.matrix_m_size = MW'(2); bus.matrix_n_size = NW'(2);
    tick();
    bus.load_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.element_valid = 1'b1;
      bus.element = 32'hA000_0000 + 32'(i);
      tick();
    end
    checkOutput("abort_load_ack_before_drop", 64'(bus.ack), 64'd1);
    bus.element_valid = 1'b0;
    bus.en = 1'b0;
    tick();
    bus.en = 1'b1;
    checkOutput("abort_load_idle", 64'(bus.ack), 64'd0);
    refValid[1] = 1'b0;
    applyStimulus(mkVec(1, 0, 1, 0, 0, 0, 1, 1, 0), "abort_store_reg1");

    // Reset while beat 5 of a 4x4 store from reg 0 is on the bus.
    bus.store_en = 1'b1; bus.store_addr = 2'd0;
    tick();
    bus.store_en  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    checkOutput("midstore_beat5_element", 64'(bus.element_out), 64'(refMem[0][4]));
    rst = 1'b1;
    tick();
    checkAllZero("midstore_reset");
    rst = 1'b0;
    bus.out_ready = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) refValid[r] = 1'b0;
    for (int r = 0; r < NUM_REGS; r++)
      applyStimulus(mkVec(1, 0, 1, 0, 0, 0, r, 1, 0), $sformatf("post_reset_store_reg%0d", r));

    runRandom(40);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end
endmodule
